// File: rtl/vec_pkg.sv
// Shared types and constants for the vector ALU sequencer.
package vec_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } seq_state_t;

  localparam int FLG_V = 0;
  localparam int FLG_C = 1;
  localparam int FLG_Z = 2;
  localparam int FLG_N = 3;

endpackage

// File: rtl/vector_alu_sequencer_alu.sv
// Scalar ALU shared by all lanes. Carry on subtract means "no borrow".
// Zero is not produced here; the sequencer derives it from the lane result.
module ALU
  import vec_pkg::*;
#(
  parameter int N = 32
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  input  alu_op_t             op,
  output logic signed [N-1:0] y,
  output logic                overflow,
  output logic                carry
);

  logic [N:0] sum;

  always_comb begin
    sum      = '0;
    y        = '0;
    overflow = 1'b0;
    carry    = 1'b0;
    case (op)
      ALU_ADD: begin
        sum      = {1'b0, a} + {1'b0, b};
        y        = sum[N-1:0];
        carry    = sum[N];
        overflow = (a[N-1] == b[N-1]) && (y[N-1] != a[N-1]);
      end
      ALU_SUB: begin
        sum      = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
        y        = sum[N-1:0];
        carry    = sum[N];
        overflow = (a[N-1] != b[N-1]) && (y[N-1] != a[N-1]);
      end
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/vector_alu_sequencer.sv
// Runs one LANES-wide vector op through a single scalar ALU, one lane per cycle,
// aggregating flags across active lanes.
module vector_alu_sequencer
  import vec_pkg::*;
#(
  parameter int N     = 32,
  parameter int LANES = 4,
  parameter int VLW   = $clog2(LANES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*N-1:0]   op_a,
  input  logic [LANES*N-1:0]   op_b,
  input  logic [1:0]           op_ctrl,
  input  logic [VLW-1:0]       vlen,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*N-1:0]   result,
  output logic [3:0]           flags,
  output logic                 busy
);

  localparam logic [VLW-1:0] LANES_V = VLW'(LANES);

  seq_state_t         state, state_nxt;
  logic [LANES*N-1:0] a_q, b_q, result_q;
  alu_op_t            op_q;
  logic [VLW-1:0]     vlen_q, idx;
  logic               v_acc, c_acc, z_acc, n_acc;

  logic [VLW-1:0]     vlen_clamp;
  logic               last_lane;
  logic signed [N-1:0] lane_a, lane_b, alu_y;
  logic               alu_v, alu_c;

  assign vlen_clamp = (vlen > LANES_V) ? LANES_V : vlen;
  assign last_lane  = ((idx + 1'b1) == vlen_q);
  assign lane_a     = a_q[idx*N +: N];
  assign lane_b     = b_q[idx*N +: N];

  ALU #(.N(N)) u_alu (
    .a        (lane_a),
    .b        (lane_b),
    .op       (op_q),
    .y        (alu_y),
    .overflow (alu_v),
    .carry    (alu_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = (vlen_clamp != '0) ? EXEC : DONE;
      EXEC:    if (last_lane) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == EXEC) || (state == DONE);
  end

  // Capture on acceptance, then one lane write and flag merge per EXEC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= ALU_ADD;
      vlen_q   <= '0;
      idx      <= '0;
      result_q <= '0;
      v_acc    <= 1'b0;
      c_acc    <= 1'b0;
      z_acc    <= 1'b0;
      n_acc    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q      <= op_a;
          b_q      <= op_b;
          op_q     <= alu_op_t'(op_ctrl);
          vlen_q   <= vlen_clamp;
          idx      <= '0;
          result_q <= '0;
          v_acc    <= 1'b0;
          c_acc    <= 1'b0;
          z_acc    <= 1'b1;
          n_acc    <= 1'b0;
        end
        EXEC: begin
          result_q[idx*N +: N] <= alu_y;
          v_acc <= v_acc | alu_v;
          c_acc <= c_acc | alu_c;
          n_acc <= n_acc | alu_y[N-1];
          z_acc <= z_acc & (alu_y == '0);
          idx   <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result       = result_q;
  assign flags[FLG_V] = v_acc;
  assign flags[FLG_C] = c_acc;
  assign flags[FLG_Z] = z_acc;
  assign flags[FLG_N] = n_acc;

endmodule
